fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Circular instruction-fetch byte buffer: requests aligned lines from the bus, stores the
// response beats and presents a sliding decode window to the decoder.
module fetch_buffer #(
   parameter int          BUF_BYTES     = 128,
   parameter int          LINE_BYTES    = 64,
   parameter int          BEAT_BYTES    = 8,
   parameter int          WINDOW        = 15,
   parameter int          REFILL_THRESH = 32,
   parameter logic [12:0] REQ_TAG       = 13'h1100
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [63:0]             entry,
   output logic                    reqcyc,
   output logic [63:0]             req,
   output logic [12:0]             reqtag,
   input  logic                    reqack,
   input  logic                    respcyc,
   input  logic [BEAT_BYTES*8-1:0] resp,
   output logic                    respack,
   output logic [WINDOW*8-1:0]     win_bytes,
   output logic                    win_valid,
   output logic [63:0]             win_addr,
   input  logic [3:0]              consume,
   input  logic                    redirect,
   input  logic [63:0]             redirect_addr
);

   localparam int AW  = $clog2(BUF_BYTES);
   localparam int PW  = AW + 1;
   localparam int NB  = LINE_BYTES / BEAT_BYTES;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
   localparam int LW  = $clog2(LINE_BYTES);
   localparam int BW  = $clog2(BEAT_BYTES);
   localparam logic [63:0] LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

   typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DRAIN} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   rd, wr, occ, cons_add, skip_add;
   logic [63:0]     fetch_addr;
   logic [LW-1:0]   start_off;
   logic [BCW-1:0]  beat_cnt, first_beat;
   logic [7:0]      mem [BUF_BYTES];
   logic            beat_in, last_beat, write_beat, take_consume, line_done;
   logic            reqcyc_n;
   logic [63:0]     req_n;
   logic [12:0]     reqtag_n;

   assign occ          = wr - rd;
   assign respack      = respcyc;
   assign win_valid    = (occ >= PW'(WINDOW)) && (state != DRAIN);
   assign first_beat   = BCW'(start_off >> BW);
   assign beat_in      = respcyc && (state != IDLE);
   assign last_beat    = (beat_cnt == BCW'(NB - 1));
   assign line_done    = beat_in && last_beat;
   assign write_beat   = beat_in && (state != DRAIN) && (beat_cnt >= first_beat) && !redirect;
   assign take_consume = win_valid && !redirect;
   assign cons_add     = take_consume ? PW'(consume) : '0;
   // The first kept beat of an unaligned start is stored whole; rd skips its leading bytes.
   assign skip_add     = (write_beat && beat_cnt == first_beat) ? PW'(start_off[BW-1:0]) : '0;

   always_comb begin
      state_n  = state;
      reqcyc_n = reqcyc;
      req_n    = req;
      reqtag_n = reqtag;
      case (state)
         IDLE: begin
            if (reqcyc) begin
               if (reqack) begin
                  reqcyc_n = 1'b0;
                  state_n  = redirect ? DRAIN : WAIT;
               end else if (redirect) begin
                  req_n = redirect_addr & LINE_MASK;
               end
            end else if (redirect) begin
               reqcyc_n = 1'b1;
               req_n    = redirect_addr & LINE_MASK;
               reqtag_n = REQ_TAG;
            end else if (occ < PW'(REFILL_THRESH)) begin
               reqcyc_n = 1'b1;
               req_n    = fetch_addr & LINE_MASK;
               reqtag_n = REQ_TAG;
            end
         end
         WAIT, ACTIVE: begin
            if (line_done)    state_n = IDLE;
            else if (redirect) state_n = DRAIN;
            else if (beat_in)  state_n = ACTIVE;
         end
         DRAIN: begin
            if (line_done) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rd         <= '0;
         wr         <= '0;
         fetch_addr <= entry;
         win_addr   <= entry;
         start_off  <= entry[LW-1:0];
         beat_cnt   <= '0;
         reqcyc     <= 1'b0;
         req        <= '0;
         reqtag     <= '0;
      end else begin
         state  <= state_n;
         reqcyc <= reqcyc_n;
         req    <= req_n;
         reqtag <= reqtag_n;
         if (beat_in) beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
         if (write_beat) wr <= wr + PW'(BEAT_BYTES);
         if (redirect) begin
            rd         <= wr;
            win_addr   <= redirect_addr;
            fetch_addr <= redirect_addr;
            start_off  <= redirect_addr[LW-1:0];
         end else begin
            rd <= rd + cons_add + skip_add;
            if (take_consume) win_addr <= win_addr + 64'(consume);
            if (line_done && state != DRAIN) begin
               fetch_addr <= fetch_addr + 64'(LINE_BYTES);
               start_off  <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (write_beat) begin
         for (int i = 0; i < BEAT_BYTES; i++) begin
            mem[AW'(wr[AW-1:0] + AW'(i))] <= resp[8*i +: 8];
         end
      end
   end

   always_comb begin
      win_bytes = '0;
      for (int i = 0; i < WINDOW; i++) begin
         win_bytes[(WINDOW-i)*8-1 -: 8] = mem[AW'(rd[AW-1:0] + AW'(i))];
      end
   end

   assert property (@(posedge clk) disable iff (!reset_n) int'(consume) <= WINDOW);

endmodule
